// File: rtl/clock_disp_pkg.sv
// clock_disp_pkg: seven-segment codes, digit indices and helpers shared by the clock display scanner
package clock_disp_pkg;
  typedef logic [1:0] dig_idx_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam dig_idx_t DIG_MU = 2'd0;
  localparam dig_idx_t DIG_MT = 2'd1;
  localparam dig_idx_t DIG_HU = 2'd2;
  localparam dig_idx_t DIG_HT = 2'd3;
  localparam logic [3:0] AN_OFF = 4'hF;
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    return (d > 4'd9) ? SEG_BLANK : SEG_DIGIT[d];
  endfunction
  function automatic logic [3:0] an_select(input dig_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/clock_display_scanner_bcd.sv
// bin6_to_bcd2: combinational split of a 0..63 binary value into decimal tens and units
module bin6_to_bcd2 (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);
  assign tens  = 4'(bin / 6'd10);
  assign units = 4'(bin % 6'd10);
endmodule

// File: rtl/clock_display_scanner.sv
// clock_display_scanner: HH:MM multiplexing onto a 4-digit common-anode display; CLOCK_DISP_BLINK_EN adds edit blink
module clock_display_scanner
  import clock_disp_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int LZ_BLANK = 1,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic       sec_pulse,
  input  logic [1:0] edit_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW = $clog2(SCAN_DIV);
  if (SCAN_DIV < 2 || BLINK_HZ < 1) begin : g_cfg_check
    $error("clock_display_scanner: SCAN_DIV must be >= 2 and BLINK_HZ >= 1");
  end
  logic [PW-1:0] presc_q, presc_d;
  dig_idx_t idx_q, idx_d;
  logic blank_q, blank_d;
  logic [5:0] snap_h_q, snap_h_d, snap_m_q, snap_m_d;
  logic colon_q, colon_d;
  logic [6:0] code_q, code_d, seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic dp_q, dp_d;
  logic tc, latch, lz_hit, edit_mask;
  logic [3:0] h_tens, h_units, m_tens, m_units, digit;
  bin6_to_bcd2 u_bcd_h (.bin(snap_h_d), .tens(h_tens), .units(h_units));
  bin6_to_bcd2 u_bcd_m (.bin(snap_m_d), .tens(m_tens), .units(m_units));
  // Scan timing: prescaler, digit index, frame snapshot and colon toggle
  always_comb begin
    tc       = presc_q == PW'(SCAN_DIV - 1);
    presc_d  = tc ? '0 : presc_q + PW'(1);
    idx_d    = tc ? (blank_q ? DIG_MU : idx_q + 2'd1) : idx_q;
    blank_d  = blank_q & ~tc;
    latch    = tc & (blank_q | (idx_q == DIG_HT));
    snap_h_d = latch ? hours : snap_h_q;
    snap_m_d = latch ? minutes : snap_m_q;
    colon_d  = colon_q ^ sec_pulse;
  end
  // Output image for the digit being entered; the new snapshot is used directly on a latching TC
  always_comb begin
    digit  = (idx_d == DIG_MU) ? m_units : (idx_d == DIG_MT) ? m_tens : (idx_d == DIG_HU) ? h_units : h_tens;
    lz_hit = (LZ_BLANK != 0) && (idx_d == DIG_HT) && (h_tens == 4'd0);
    code_d = tc ? (lz_hit ? SEG_BLANK : seg_encode(digit)) : code_q;
    an_d   = tc ? an_select(idx_d) : an_q;
    dp_d   = tc ? ((idx_d == DIG_HU) ? ~colon_d : 1'b1) : dp_q;
    seg_d  = edit_mask ? SEG_BLANK : code_d;
  end
`ifdef CLOCK_DISP_BLINK_EN
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic phase_q, phase_d, blink_wrap;
  // Blink phase generator and live edit-field mask
  always_comb begin
    blink_wrap  = blink_cnt_q == BW'(BLINK_DIV - 1);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    phase_d     = phase_q ^ blink_wrap;
    edit_mask   = ~phase_d & (idx_d[1] ? edit_sel[1] : edit_sel[0]);
  end
  // Blink state registers; phase restarts in the visible half
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  logic unused_edit;
  assign edit_mask   = 1'b0;
  assign unused_edit = ^edit_sel;
`endif
  // State and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= DIG_MU;
      blank_q  <= 1'b1;
      snap_h_q <= '0;
      snap_m_q <= '0;
      colon_q  <= 1'b0;
      code_q   <= SEG_BLANK;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      blank_q  <= blank_d;
      snap_h_q <= snap_h_d;
      snap_m_q <= snap_m_d;
      colon_q  <= colon_d;
      code_q   <= code_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end
  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
endmodule
